// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - handshaked four-op ALU with a shift-add multiplier
module multicycle_alu #(
  parameter int Width = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [Width-1:0]   A,
  input  logic [Width-1:0]   B,
  input  logic [1:0]         Sel,
  input  logic               InValid,
  output logic               InReady,
  output logic [2*Width-1:0] Out,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               Busy
);

  localparam int CW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(Width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2*Width-1:0] acc;
  logic [2*Width-1:0] mcand;
  logic [Width-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*Width-1:0] out_q;
  logic [2*Width-1:0] acc_step;
  logic [2*Width-1:0] simple_res;
  logic               accept;

  // State register; reset drops any in-flight operation
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    InReady    = 1'b0;
    OutValid   = 1'b0;
    Busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
        accept  = InValid;
        if (InValid) begin
          state_next = (Sel == 2'b10) ? MUL : DONE;
        end
      end
      MUL: begin
        Busy = 1'b1;
        // The last partial product lands in Out on this edge
        if (cnt == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Busy     = 1'b1;
        OutValid = 1'b1;
        if (OutReady) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Single-cycle results and the next shift-add accumulator value
  always_comb begin
    acc_step   = mplier[0] ? (acc + mcand) : acc;
    simple_res = '0;
    case (Sel)
      2'b00:   simple_res = {{Width{1'b0}}, A} + {{Width{1'b0}}, B};
      2'b01:   simple_res = {{Width{1'b0}}, A & B};
      2'b11:   simple_res = {{Width{1'b0}}, A} + (2*Width)'(1);
      default: simple_res = '0;
    endcase
  end

  // Datapath: operand capture at accept, one multiplier bit per MUL cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      out_q  <= '0;
    end else begin
      if (accept) begin
        if (Sel == 2'b10) begin
          acc    <= '0;
          mcand  <= {{Width{1'b0}}, A};
          mplier <= B;
          cnt    <= '0;
        end else begin
          out_q <= simple_res;
        end
      end else if (state == MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == LAST_STEP) begin
          out_q <= acc_step;
        end
      end
    end
  end

  assign Out = out_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu
module tb_multicycle_alu;

  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RST;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     Sel;
  logic           InValid;
  logic           InReady;
  logic [2*W-1:0] Out;
  logic           OutValid;
  logic           OutReady;
  logic           Busy;

  typedef struct {
    logic [2*W-1:0] res;
    int             acc_cyc;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  multicycle_alu #(.Width(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .InValid  (InValid),
    .InReady  (InReady),
    .Out      (Out),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic logic [2*W-1:0] model(input int a, input int b, input int s);
    int r;
    case (s)
      0:       r = a + b;
      1:       r = a & b;
      2:       r = a * b;
      default: r = a + 1;
    endcase
    return r[2*W-1:0];
  endfunction

  // Monitor: compares each new result and the hold/release protocol
  initial begin : monitor
    logic           prev_valid;
    logic           prev_ready;
    logic [2*W-1:0] prev_out;
    exp_t           e;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
      end else begin
        check("ready_vs_busy", InReady, !Busy);
        if (prev_valid && !prev_ready) check("hold_valid", OutValid, 1);
        if (prev_valid && prev_ready) check("release", OutValid, 0);
        if (OutValid && prev_valid) check("hold_stable", Out, prev_out);
        if (OutValid && !prev_valid) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result got=%0d want=none", Out);
          end else begin
            e = sb.pop_front();
            check("result", Out, e.res);
            check("latency", cyc - e.acc_cyc + 1, e.lat);
          end
        end
        prev_valid = OutValid;
        prev_ready = OutReady;
        prev_out   = Out;
      end
    end
  end

  task automatic issue(input int a, input int b, input int s);
    int n;
    A       = W'(a);
    B       = W'(b);
    Sel     = 2'(s);
    InValid = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!InReady && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!InReady) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=busy want=ready");
      InValid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    sb.push_back('{model(a, b, s), cyc, (s == 2) ? W + 1 : 1});
    InValid = 1'b0;
    A       = W'($urandom);
    B       = W'($urandom);
    Sel     = 2'($urandom);
  endtask

  task automatic drain(input bit rnd_ready);
    int n;
    n = 0;
    while ((sb.size() != 0 || OutValid) && n < 100) begin
      @(posedge CLK);
      #1;
      if (rnd_ready) OutReady = 1'($urandom_range(0, 1));
      n++;
    end
    if (sb.size() != 0 || OutValid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=pending want=idle");
      sb.delete();
    end
    OutReady = 1'b1;
  endtask

  initial begin
    RST      = 1'b1;
    A        = '0;
    B        = '0;
    Sel      = '0;
    InValid  = 1'b0;
    OutReady = 1'b1;
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", OutValid, 0);
    check("rst_out", Out, 0);
    check("rst_in_ready", InReady, 1);
    check("rst_busy", Busy, 0);
    RST = 1'b1;

    issue(5, 15, 0);
    drain(0);
    check("t1_idle", InReady, 1);
    check("t1_out_kept", Out, 20);

    issue(12, 10, 1);
    drain(0);
    issue(255, 0, 3);
    drain(0);

    issue(255, 255, 2);
    drain(0);
    issue(0, 200, 2);
    drain(0);

    OutReady = 1'b0;
    issue(20, 0, 0);
    A       = 8'd99;
    B       = 8'd1;
    Sel     = 2'b00;
    InValid = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    InValid = 1'b0;
    check("t5_held_valid", OutValid, 1);
    check("t5_held_out", Out, 20);
    OutReady = 1'b1;
    @(posedge CLK);
    #1;
    check("t5_released", OutValid, 0);
    check("t5_sb_empty", sb.size(), 0);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check("t5_second_ignored", InReady, 1);

    issue(7, 3, 2);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("t6_rst_valid", OutValid, 0);
    check("t6_rst_out", Out, 0);
    check("t6_rst_ready", InReady, 1);
    check("t6_rst_busy", Busy, 0);
    sb.delete();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    issue(7, 3, 2);
    drain(0);
    check("t6_out_after", Out, 21);

    for (int i = 0; i <= 20 && failures == 0; i++) begin
      for (int s = 0; s < 4 && failures == 0; s++) begin
        issue(i, 20 - i, s);
        drain(0);
      end
    end

    for (int k = 0; k < 40 && failures == 0; k++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      drain(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
